// File: rtl/sm83_fetch_if.sv
// rtl/sm83_fetch_if.sv - byte-read memory port between the fetch unit and memory
interface sm83_fetch_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/sm83_fetch.sv
// rtl/sm83_fetch.sv - SM83 instruction-byte fetch with one-entry output buffer and CB-prefix tracking
module sm83_fetch #(
  parameter logic [15:0] RESET_PC      = 16'h0000,
  parameter logic [7:0]  PREFIX_OPCODE = 8'hCB
) (
  input  logic              clk,
  input  logic              rst_n,
  sm83_fetch_if.master      mem,
  output logic [7:0]        o_instr,
  output logic              o_is_instr16,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [15:0]       o_pc,
  input  logic              i_redirect,
  input  logic [15:0]       i_redirect_pc,
  input  logic              i_halt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [15:0] fetch_pc, fetch_pc_d;
  logic        prefix_pending, prefix_pending_d;
  logic [7:0]  instr_d;
  logic        is_instr16_d;
  logic        valid_d;
  logic [15:0] pc_d;

  // Memory request is a pure function of registered state.
  assign mem.mem_req  = (state == REQ);
  assign mem.mem_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      fetch_pc       <= RESET_PC;
      prefix_pending <= 1'b0;
      o_instr        <= 8'h00;
      o_is_instr16   <= 1'b0;
      o_valid        <= 1'b0;
      o_pc           <= RESET_PC;
    end else begin
      state          <= state_d;
      fetch_pc       <= fetch_pc_d;
      prefix_pending <= prefix_pending_d;
      o_instr        <= instr_d;
      o_is_instr16   <= is_instr16_d;
      o_valid        <= valid_d;
      o_pc           <= pc_d;
    end
  end

  always_comb begin
    state_d          = state;
    fetch_pc_d       = fetch_pc;
    prefix_pending_d = prefix_pending;
    instr_d          = o_instr;
    is_instr16_d     = o_is_instr16;
    valid_d          = o_valid;
    pc_d             = o_pc;

    // Redirect wins over everything, including a same-cycle ack whose data is dropped.
    if (i_redirect) begin
      fetch_pc_d       = i_redirect_pc;
      valid_d          = 1'b0;
      prefix_pending_d = 1'b0;
      state_d          = i_halt ? IDLE : REQ;
    end else begin
      case (state)
        IDLE: begin
          if (!i_halt) state_d = REQ;
        end
        REQ: begin
          if (mem.mem_ack) begin
            instr_d      = mem.mem_rdata;
            is_instr16_d = prefix_pending;
            pc_d         = fetch_pc;
            valid_d      = 1'b1;
            fetch_pc_d   = fetch_pc + 16'd1;
            state_d      = HOLD;
          end
        end
        HOLD: begin
          if (i_ready) begin
            valid_d = 1'b0;
            // A CB that is itself the second byte is a CB-page opcode and does not re-arm.
            prefix_pending_d = (o_instr == PREFIX_OPCODE) && !o_is_instr16;
            state_d          = i_halt ? IDLE : REQ;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm83_fetch.sv
// tb/tb_sm83_fetch.sv - directed self-checking bench for sm83_fetch
module tb_sm83_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  o_instr;
  logic        o_is_instr16;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_pc;
  logic        i_redirect;
  logic [15:0] i_redirect_pc;
  logic        i_halt;

  int tests = 0;
  int failed = 0;
  int ack_delay = 0;
  int wait_cnt;

  logic [7:0] mem [0:65535];

  sm83_fetch_if bus();

  sm83_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem           (bus),
    .o_instr       (o_instr),
    .o_is_instr16  (o_is_instr16),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_pc          (o_pc),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_halt        (i_halt)
  );

  always #5 clk = ~clk;

  // Memory responder: ack after ack_delay wait cycles of an outstanding request.
  assign bus.mem_ack   = bus.mem_req && (wait_cnt >= ack_delay);
  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (bus.mem_req && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    tests++; if (bus.mem_req !== 1'b0) begin failed++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
    tests++; if (bus.mem_addr !== 16'h0000) begin failed++; $display("FAIL reset_mem_addr: got %h expected 0000", bus.mem_addr); end
    tests++; if (o_valid !== 1'b0 || o_instr !== 8'h00 || o_is_instr16 !== 1'b0) begin failed++; $display("FAIL reset_buffer: got valid=%b instr=%h is16=%b expected 0/00/0", o_valid, o_instr, o_is_instr16); end
    tests++; if (o_pc !== 16'h0000) begin failed++; $display("FAIL reset_o_pc: got %h expected 0000", o_pc); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_sequential;
    for (int k = 0; k < 3; k++) begin
      tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'(k)) begin failed++; $display("FAIL seq_req[%0d]: got req=%b addr=%h expected 1/%h", k, bus.mem_req, bus.mem_addr, 16'(k)); end
      tick;
      tests++; if (o_valid !== 1'b1 || o_instr !== 8'h00 || o_pc !== 16'(k) || o_is_instr16 !== 1'b0) begin failed++; $display("FAIL seq_out[%0d]: got v=%b instr=%h pc=%h is16=%b expected 1/00/%h/0", k, o_valid, o_instr, o_pc, o_is_instr16, 16'(k)); end
      tests++; if (bus.mem_req !== 1'b0) begin failed++; $display("FAIL seq_hold_req[%0d]: got %b expected 0", k, bus.mem_req); end
      tick;
    end
  endtask

  task automatic test_prefix;
    logic [7:0] bytes [6];
    logic       exp16 [6];
    bytes = '{8'hCB, 8'h37, 8'hCB, 8'hCB, 8'hCB, 8'h00};
    exp16 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 6; k++) begin
      tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'(3 + k)) begin failed++; $display("FAIL prefix_req[%0d]: got req=%b addr=%h expected 1/%h", k, bus.mem_req, bus.mem_addr, 16'(3 + k)); end
      tick;
      tests++; if (o_valid !== 1'b1 || o_instr !== bytes[k] || o_is_instr16 !== exp16[k] || o_pc !== 16'(3 + k)) begin failed++; $display("FAIL prefix_out[%0d]: got v=%b instr=%h is16=%b pc=%h expected 1/%h/%b/%h", k, o_valid, o_instr, o_is_instr16, o_pc, bytes[k], exp16[k], 16'(3 + k)); end
      tick;
    end
  endtask

  task automatic test_stall;
    tests++; if (bus.mem_addr !== 16'h0009) begin failed++; $display("FAIL stall_addr: got %h expected 0009", bus.mem_addr); end
    i_ready = 1'b0;
    tick;
    for (int k = 0; k < 5; k++) begin
      tests++; if (o_valid !== 1'b1 || o_instr !== 8'h3E || o_pc !== 16'h0009 || bus.mem_req !== 1'b0) begin failed++; $display("FAIL stall_hold[%0d]: got v=%b instr=%h pc=%h req=%b expected 1/3e/0009/0", k, o_valid, o_instr, o_pc, bus.mem_req); end
      tick;
    end
    i_ready = 1'b1;
    tick;
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h000A || o_valid !== 1'b0) begin failed++; $display("FAIL stall_release: got req=%b addr=%h v=%b expected 1/000a/0", bus.mem_req, bus.mem_addr, o_valid); end
  endtask

  task automatic test_wait_states;
    ack_delay = 3;
    for (int k = 0; k < 4; k++) begin
      tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h000A || o_valid !== 1'b0) begin failed++; $display("FAIL wait_req[%0d]: got req=%b addr=%h v=%b expected 1/000a/0", k, bus.mem_req, bus.mem_addr, o_valid); end
      tick;
    end
    tests++; if (o_valid !== 1'b1 || o_instr !== 8'h5A || o_pc !== 16'h000A) begin failed++; $display("FAIL wait_out: got v=%b instr=%h pc=%h expected 1/5a/000a", o_valid, o_instr, o_pc); end
    ack_delay = 0;
    tick;
  endtask

  task automatic test_redirect;
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h000B) begin failed++; $display("FAIL redir_pre: got req=%b addr=%h expected 1/000b", bus.mem_req, bus.mem_addr); end
    i_redirect = 1'b1; i_redirect_pc = 16'h00FF;
    tick;
    i_redirect = 1'b0;
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h00FF || o_valid !== 1'b0) begin failed++; $display("FAIL redir_ff: got req=%b addr=%h v=%b expected 1/00ff/0", bus.mem_req, bus.mem_addr, o_valid); end
    tick;
    tests++; if (o_valid !== 1'b1 || o_instr !== 8'hCB || o_is_instr16 !== 1'b0 || o_pc !== 16'h00FF) begin failed++; $display("FAIL redir_cb: got v=%b instr=%h is16=%b pc=%h expected 1/cb/0/00ff", o_valid, o_instr, o_is_instr16, o_pc); end
    tick;
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0100) begin failed++; $display("FAIL redir_100: got req=%b addr=%h expected 1/0100", bus.mem_req, bus.mem_addr); end
    i_redirect = 1'b1; i_redirect_pc = 16'h0038;
    tick;
    i_redirect = 1'b0;
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0038 || o_valid !== 1'b0) begin failed++; $display("FAIL redir_38: got req=%b addr=%h v=%b expected 1/0038/0", bus.mem_req, bus.mem_addr, o_valid); end
    tick;
    tests++; if (o_valid !== 1'b1 || o_instr !== 8'h11 || o_is_instr16 !== 1'b0 || o_pc !== 16'h0038) begin failed++; $display("FAIL redir_38_out: got v=%b instr=%h is16=%b pc=%h expected 1/11/0/0038", o_valid, o_instr, o_is_instr16, o_pc); end
    tick;
  endtask

  task automatic test_wrap;
    i_redirect = 1'b1; i_redirect_pc = 16'hFFFF;
    tick;
    i_redirect = 1'b0;
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'hFFFF) begin failed++; $display("FAIL wrap_req: got req=%b addr=%h expected 1/ffff", bus.mem_req, bus.mem_addr); end
    tick;
    tests++; if (o_valid !== 1'b1 || o_instr !== 8'hA5 || o_pc !== 16'hFFFF) begin failed++; $display("FAIL wrap_ffff: got v=%b instr=%h pc=%h expected 1/a5/ffff", o_valid, o_instr, o_pc); end
    tick;
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0000) begin failed++; $display("FAIL wrap_req0: got req=%b addr=%h expected 1/0000", bus.mem_req, bus.mem_addr); end
    tick;
    tests++; if (o_valid !== 1'b1 || o_instr !== 8'h00 || o_pc !== 16'h0000) begin failed++; $display("FAIL wrap_0000: got v=%b instr=%h pc=%h expected 1/00/0000", o_valid, o_instr, o_pc); end
    tick;
  endtask

  task automatic test_halt;
    ack_delay = 2;
    i_halt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0001) begin failed++; $display("FAIL halt_inflight[%0d]: got req=%b addr=%h expected 1/0001", k, bus.mem_req, bus.mem_addr); end
      tick;
    end
    tests++; if (o_valid !== 1'b1 || o_pc !== 16'h0001) begin failed++; $display("FAIL halt_deliver: got v=%b pc=%h expected 1/0001", o_valid, o_pc); end
    ack_delay = 0;
    tick;
    for (int k = 0; k < 3; k++) begin
      tests++; if (bus.mem_req !== 1'b0 || o_valid !== 1'b0) begin failed++; $display("FAIL halt_idle[%0d]: got req=%b v=%b expected 0/0", k, bus.mem_req, o_valid); end
      tick;
    end
    i_halt = 1'b0;
    tick;
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0002) begin failed++; $display("FAIL halt_resume: got req=%b addr=%h expected 1/0002", bus.mem_req, bus.mem_addr); end
  endtask

  task automatic test_async_reset;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 16'h0000 || o_valid !== 1'b0) begin failed++; $display("FAIL async_reset: got req=%b addr=%h v=%b expected 0/0000/0", bus.mem_req, bus.mem_addr, o_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    i_ready = 1'b1;
    i_redirect = 1'b0;
    i_redirect_pc = 16'h0000;
    i_halt = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[3] = 8'hCB; mem[4] = 8'h37; mem[5] = 8'hCB;
    mem[6] = 8'hCB; mem[7] = 8'hCB; mem[8] = 8'h00;
    mem[16'h0009] = 8'h3E;
    mem[16'h000A] = 8'h5A;
    mem[16'h000B] = 8'h42;
    mem[16'h00FF] = 8'hCB;
    mem[16'h0100] = 8'h77;
    mem[16'h0038] = 8'h11;
    mem[16'hFFFF] = 8'hA5;
    repeat (2) tick;
    test_reset;
    test_sequential;
    test_prefix;
    test_stall;
    test_wait_states;
    test_redirect;
    test_wrap;
    test_halt;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/sm83_fetch.md
# sm83_fetch

Instruction-byte fetch unit for the SM83 core. It sits between the memory port and the `decode` stage and produces the `instr` / `i_is_instr16` pair that `decode` consumes. It holds the fetch PC and issues one byte read at a time over a req/ack handshake. Each returned opcode byte is presented in a one-entry output buffer under valid/ready. The unit also tracks the 0xCB prefix, so the byte after a prefix is flagged as the second byte of a 16-bit instruction. Control can redirect the PC for jumps, calls, returns and interrupts, and can halt fetch.

## Interface
- `RESET_PC`, 16'h0000, fetch address after reset.
- `PREFIX_OPCODE`, 8'hCB, opcode value that marks a 16-bit instruction.

- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_req`  out  1  byte read request.
- `mem_addr`  out  16  read address; held stable while `mem_req`=1.
- `mem_ack`  in  1  read complete; only meaningful when `mem_req`=1.
- `mem_rdata`  in  8  read data; valid in the `mem_ack` cycle.
- `o_instr`  out  8  buffered opcode byte, to `decode.instr`.
- `o_is_instr16`  out  1  buffered byte follows an accepted prefix, to `decode.i_is_instr16`.
- `o_valid`  out  1  buffer holds a byte.
- `i_ready`  in  1  consumer accepts the byte this cycle.
- `o_pc`  out  16  address the buffered byte was fetched from.
- `i_redirect`  in  1  load a new fetch PC (one-cycle pulse).
- `i_redirect_pc`  in  16  new fetch PC.
- `i_halt`  in  1  level; suppress new requests.

## Operation
- Registers:
  - `fetch_pc` (16b): next address to read.
  - `prefix_pending` (1b).
  - Output buffer: `o_instr`, `o_is_instr16`, `o_pc`, `o_valid`.
- FSM states:
  - IDLE: no request.
  - REQ: `mem_req`=1 and `mem_addr`=`fetch_pc`.
  - HOLD: `o_valid`=1, waiting for `i_ready`.
- `mem_req` and `mem_addr` decode directly from state and registers. No combinational path from any input to `mem_req`.
- Transitions, in priority order:
  - `i_redirect`=1 (any state):
    - `fetch_pc`←`i_redirect_pc`.
    - `o_valid`←0 and `prefix_pending`←0.
    - Data arriving with `mem_ack` in the same cycle is discarded.
    - Next state is REQ if `i_halt`=0, otherwise IDLE.
  - IDLE: goes to REQ when `i_halt`=0.
  - REQ with `mem_ack`=1:
    - Buffer←{`mem_rdata`, `prefix_pending`, `fetch_pc`}.
    - `fetch_pc`←`fetch_pc`+1, wrapping 16'hFFFF→16'h0000.
    - Next state HOLD.
  - REQ with `mem_ack`=0: stays in REQ. The request is not withdrawn except by redirect. `i_halt` does not cancel an outstanding request.
  - HOLD with `i_ready`=1 (handshake):
    - `o_valid`←0.
    - `prefix_pending`←(`o_instr`==`PREFIX_OPCODE` && !`o_is_instr16`).
    - Next state is REQ if `i_halt`=0, otherwise IDLE.
  - HOLD with `i_ready`=0: buffer holds all values stable.
- Prefix rules:
  - The prefix byte itself is presented with `o_is_instr16`=0.
  - The following byte is presented with `o_is_instr16`=1.
  - CB CB sequence: the second CB is the CB-page opcode (`o_is_instr16`=1), and it does not re-arm the prefix.
- Halt: `i_halt` only gates entry to REQ. An in-flight request completes, and the buffered byte is still delivered.

## Timing
- Reset values (async assert):
  - state=IDLE, `mem_req`=0, `mem_addr`=`RESET_PC`.
  - `fetch_pc`=`RESET_PC`, `o_pc`=`RESET_PC`.
  - `o_instr`=8'h00, `o_is_instr16`=0, `o_valid`=0, `prefix_pending`=0.
- First `mem_req` is in the first cycle after the first rising edge following reset release.
- Latency:
  - `mem_ack` in cycle N gives `o_valid`=1 in cycle N+1.
  - A handshake in cycle M gives `mem_req`=1 in cycle M+1.
  - Best-case throughput: one byte per 2 cycles, with zero-wait memory and `i_ready` held at 1.
- Memory handshake: `mem_ack` may arrive in the first REQ cycle.
- Redirect:
  - Takes effect at the clock edge of the pulse.
  - The REQ at the new PC appears the next cycle.
  - `o_valid` is 0 that next cycle, even if `i_ready` was high in the redirect cycle. The consumer must not rely on acceptance of a byte flushed in the redirect cycle.
- Reset asserted mid-request: `mem_req` drops immediately (async). The memory side must tolerate an abandoned request.

## Test plan
- Reset, zero-wait memory returning 8'h00 at 0x0000..0x0002, `i_ready`=1 → `mem_addr` sequence 0x0000, 0x0001, 0x0002 on alternating cycles; `o_pc` matches each `o_instr`; `o_is_instr16`=0 throughout.
- Bytes CB, 37, CB, CB, CB, 00 → `o_is_instr16` sequence 0, 1, 0, 1, 0, 1.
- Hold `i_ready`=0 for 5 cycles with byte 3E buffered → `o_valid`, `o_instr`=3E and `o_pc` stable for all 5 cycles; `mem_req`=0.
- `mem_ack` delayed 3 cycles → `mem_addr` stable for 4 cycles; byte captured only on ack.
- Redirect to 0x0038 in the same cycle as `mem_ack` for 0x0100 → the 0x0100 data is never presented; next `mem_addr`=0x0038; prefix flag cleared.
- Redirect to 0xFFFF → bytes at 0xFFFF then 0x0000 are presented, with `o_pc` wrapping to 0x0000.
- `i_halt`=1 raised while REQ is outstanding → the ack'd byte is delivered; no further `mem_req` until `i_halt`=0, then REQ the following cycle.
